// File: rtl/rx_stp_8_bit.sv
// Receive serial-to-parallel byte assembler: LSB-first shift, byte handshake, overrun detect.
// Optional bit de-stuffing with violation flag is enabled by defining RX_UNSTUFF_EN.
module rx_stp_8_bit #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                byte_ack,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                byte_valid,
  output logic [2:0]          bit_count,
  output logic                overrun,
  output logic                stuff_err
);

  logic [NUM_BITS-1:0] sr;
  logic [NUM_BITS-1:0] next_byte;
  logic                stuff_bit;
  logic                accept;
  logic                complete;

`ifdef RX_UNSTUFF_EN
  logic [2:0] ones;

  // After six consecutive accepted ones the following strobe carries a stuff bit.
  assign stuff_bit = shift_enable && (ones == 3'd6);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ones      <= '0;
      stuff_err <= 1'b0;
    end else if (stuff_bit) begin
      ones <= '0;
      if (serial_in)
        stuff_err <= 1'b1;
    end else if (accept) begin
      ones <= serial_in ? ones + 3'd1 : 3'd0;
    end
  end
`else
  assign stuff_bit = 1'b0;
  assign stuff_err = 1'b0;
`endif

  assign accept    = shift_enable && !stuff_bit;
  assign complete  = accept && (bit_count == 3'(NUM_BITS - 1));
  assign next_byte = {serial_in, sr[NUM_BITS-1:1]};

  // Stage p0: shift register, bit counter and byte handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      sr           <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      byte_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      sr         <= '0;
      bit_count  <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        sr        <= next_byte;
        bit_count <= bit_count + 3'd1;
      end
      if (complete) begin
        parallel_out <= next_byte;
        byte_valid   <= 1'b1;
        if (byte_valid && !byte_ack)
          overrun <= 1'b1;
      end else if (byte_ack) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_stp_8_bit.sv
// Self-checking bench for rx_stp_8_bit: directed handshake/clear/stuffing cases plus a
// randomized byte stream scored against a bit-queue reference model.
module tb_rx_stp_8_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       shift_enable = 1'b0;
  logic       serial_in = 1'b0;
  logic       byte_ack = 1'b0;
  logic [7:0] parallel_out;
  logic       byte_valid;
  logic [2:0] bit_count;
  logic       overrun;
  logic       stuff_err;

  int tests = 0;
  int fails = 0;

  bit         bits_q[$];
  logic [7:0] sb[$];
  int         run = 0;
  int         pushed = 0;
  int         popped = 0;
  bit         mon_en = 1'b0;

  rx_stp_8_bit #(.NUM_BITS(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .serial_in(serial_in), .byte_ack(byte_ack), .parallel_out(parallel_out),
    .byte_valid(byte_valid), .bit_count(bit_count), .overrun(overrun),
    .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: collect data bits in arrival order, emit a byte every eight.
  task automatic model_bit(input bit b);
    logic [7:0] v;
`ifdef RX_UNSTUFF_EN
    if (run == 6) begin
      run = 0;
      return;
    end
    run = b ? run + 1 : 0;
`endif
    bits_q.push_back(b);
    if (bits_q.size() == 8) begin
      for (int i = 0; i < 8; i++) v[i] = bits_q[i];
      sb.push_back(v);
      pushed++;
      bits_q.delete();
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    run = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit b);
    shift_enable = 1'b1;
    serial_in    = b;
    model_bit(b);
    tick();
    shift_enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit ack_last);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) byte_ack = ack_last;
      strobe(v[i]);
      byte_ack = 1'b0;
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: acknowledges every presented byte, so each valid cycle carries a fresh byte.
  always @(negedge clk) begin
    if (mon_en) begin
      if (byte_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rand_byte: got 0x%0h, expected none (scoreboard empty)", parallel_out);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          tests--;
          check("rand_byte", parallel_out, e);
        end
        popped++;
        byte_ack = 1'b1;
      end else begin
        byte_ack = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] b;
    tick();
    do_rst();
    check("rst_po", parallel_out, 8'h00);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_bc", bit_count, 3'd0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_serr", stuff_err, 1'b0);

    // 0xA5 back-to-back
    b = 8'hA5;
    for (int i = 0; i < 7; i++) strobe(b[i]);
    check("a5_bc7", bit_count, 3'd7);
    check("a5_early_valid", byte_valid, 1'b0);
    strobe(b[7]);
    check("a5_valid", byte_valid, 1'b1);
    check("a5_po", parallel_out, 8'hA5);
    check("a5_bc0", bit_count, 3'd0);
    byte_ack = 1'b1;
    tick();
    byte_ack = 1'b0;
    check("a5_acked", byte_valid, 1'b0);

    // Overrun: second byte completes while first unacknowledged
    send_byte(8'h3C, 1'b0);
    check("ovr_first_po", parallel_out, 8'h3C);
    check("ovr_first_ovr", overrun, 1'b0);
    send_byte(8'h81, 1'b0);
    check("ovr_po", parallel_out, 8'h81);
    check("ovr_valid", byte_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);

    // Completion coinciding with ack: no overrun
    do_rst();
    send_byte(8'h3C, 1'b0);
    send_byte(8'h81, 1'b1);
    check("ackc_po", parallel_out, 8'h81);
    check("ackc_valid", byte_valid, 1'b1);
    check("ackc_ovr", overrun, 1'b0);

    // Clear mid-byte (with coinciding strobe) drops partial byte, valid and overrun
    send_byte(8'hC3, 1'b0);
    check("clr_pre_ovr", overrun, 1'b1);
    strobe(1'b1); strobe(1'b1); strobe(1'b0);
    clear = 1'b1;
    shift_enable = 1'b1;
    serial_in = 1'b1;
    tick();
    clear = 1'b0;
    shift_enable = 1'b0;
    model_reset();
    check("clr_bc", bit_count, 3'd0);
    check("clr_valid", byte_valid, 1'b0);
    check("clr_ovr", overrun, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("clr_po", parallel_out, 8'h5A);
    check("clr_valid2", byte_valid, 1'b1);
    check("clr_ovr2", overrun, 1'b0);

    // Reset mid-byte
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    do_rst();
    check("rstm_po", parallel_out, 8'h00);
    check("rstm_valid", byte_valid, 1'b0);
    check("rstm_bc", bit_count, 3'd0);
    send_byte(8'h5A, 1'b0);
    check("rstm_rx", parallel_out, 8'h5A);

    // Six ones, then 0, 0, 0
    do_rst();
    for (int i = 0; i < 6; i++) strobe(1'b1);
    strobe(1'b0); strobe(1'b0); strobe(1'b0);
    check("stf_po", parallel_out, 8'h3F);
    check("stf_valid", byte_valid, 1'b1);
    check("stf_serr", stuff_err, 1'b0);
`ifdef RX_UNSTUFF_EN
    check("stf_bc", bit_count, 3'd0);
`else
    check("stf_bc", bit_count, 3'd1);
`endif

    // Seven consecutive ones
    do_rst();
    for (int i = 0; i < 7; i++) strobe(1'b1);
`ifdef RX_UNSTUFF_EN
    check("seven_bc", bit_count, 3'd6);
    check("seven_serr", stuff_err, 1'b1);
`else
    check("seven_bc", bit_count, 3'd7);
    check("seven_serr", stuff_err, 1'b0);
`endif

    // Randomized stream with idle gaps, scored by the monitor
    do_rst();
    sb.delete();
    pushed = 0;
    popped = 0;
    mon_en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        strobe(b[i]);
        repeat ($urandom_range(0, 5)) tick();
      end
    end
    repeat (20) tick();
    mon_en = 1'b0;
    byte_ack = 1'b0;
    check("rand_drained", sb.size(), 0);
    check("rand_count", popped, pushed);
    check("rand_ovr", overrun, 1'b0);
    check("rand_valid_done", byte_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
